// File: rtl/nios2_dct_trace_packer.sv
// Nios II OCI DCT trace packer: shifts 2-bit branch codes into a 30-bit buffer and
// hands closed {count, buffer} frames to the trace FIFO over valid/ready.
module nios2_dct_trace_packer #(
    parameter int unsigned ENTRY_W = 2,
    parameter int unsigned DEPTH   = 15,
    parameter int unsigned CNT_W   = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           trace_en,
    input  logic                           dct_valid,
    input  logic [ENTRY_W-1:0]             dct_code,
    input  logic                           flush_req,
    input  logic                           test_ending,
    input  logic                           overflow_clr,
    input  logic                           frm_ready,
    output logic                           frm_valid,
    output logic [CNT_W+ENTRY_W*DEPTH-1:0] frm_data,
    output logic [ENTRY_W*DEPTH-1:0]       dct_buffer,
    output logic [CNT_W-1:0]               dct_count,
    output logic                           busy,
    output logic                           overflow
);

    localparam int unsigned BUF_W = ENTRY_W * DEPTH;
    localparam int unsigned FRM_W = CNT_W + BUF_W;

    typedef enum logic [1:0] {StIdle, StCollect, StStall, StDrain} state_e;

    state_e             state_q, state_d;
    logic [BUF_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               frm_valid_q, frm_valid_d;
    logic [FRM_W-1:0]   frm_data_q, frm_data_d;
    logic               overflow_q, overflow_d;
    logic               end_pend_q, end_pend_d;

    logic [BUF_W-1:0]   next_buf;
    logic [CNT_W-1:0]   next_cnt;
    logic               out_free;
    logic               ending;
    logic               close;

    // Buffer/count as they would be after accepting this cycle's code.
    always_comb begin
        next_buf = dct_valid ? {buf_q[BUF_W-ENTRY_W-1:0], dct_code} : buf_q;
        next_cnt = cnt_q + CNT_W'(dct_valid);
        out_free = ~frm_valid_q | frm_ready;
        ending   = ~trace_en | test_ending;
        close    = (next_cnt == CNT_W'(DEPTH)) | flush_req | ending;
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        frm_valid_d = frm_valid_q & ~frm_ready;
        frm_data_d  = frm_data_q;
        overflow_d  = overflow_q & ~overflow_clr;
        end_pend_d  = end_pend_q;

        unique case (state_q)
            StIdle: begin
                if (trace_en) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                buf_d = next_buf;
                cnt_d = next_cnt;
                if (close) begin
                    if (next_cnt == '0) begin
                        state_d = ending ? StDrain : StCollect;
                    end else if (out_free) begin
                        frm_valid_d = 1'b1;
                        frm_data_d  = {next_cnt, next_buf};
                        buf_d       = '0;
                        cnt_d       = '0;
                        state_d     = ending ? StDrain : StCollect;
                    end else begin
                        state_d    = StStall;
                        end_pend_d = test_ending;
                    end
                end
            end
            StStall: begin
                if (dct_valid) begin
                    overflow_d = 1'b1;
                end
                if (test_ending) begin
                    end_pend_d = 1'b1;
                end
                // frm_valid is always set here, so ready alone means a transfer.
                if (frm_ready) begin
                    frm_valid_d = 1'b1;
                    frm_data_d  = {cnt_q, buf_q};
                    buf_d       = '0;
                    cnt_d       = '0;
                    end_pend_d  = 1'b0;
                    state_d     = (~trace_en | end_pend_q | test_ending) ? StDrain : StCollect;
                end
            end
            StDrain: begin
                if (out_free) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            buf_q       <= '0;
            cnt_q       <= '0;
            frm_valid_q <= 1'b0;
            frm_data_q  <= '0;
            overflow_q  <= 1'b0;
            end_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            frm_valid_q <= frm_valid_d;
            frm_data_q  <= frm_data_d;
            overflow_q  <= overflow_d;
            end_pend_q  <= end_pend_d;
        end
    end

    assign frm_valid  = frm_valid_q;
    assign frm_data   = frm_data_q;
    assign dct_buffer = buf_q;
    assign dct_count  = cnt_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q != StIdle) | frm_valid_q;

endmodule

// File: tb/tb_nios2_dct_trace_packer.sv
// Bench for nios2_dct_trace_packer: directed scenarios plus random traffic, all checked
// against a queue-based reference model of the trace packer.
module tb_nios2_dct_trace_packer;

    localparam int DEPTH = 15;

    logic        clk = 1'b0;
    logic        reset, trace_en, dct_valid, flush_req, test_ending, overflow_clr, frm_ready;
    logic [1:0]  dct_code;
    logic        frm_valid, busy, overflow;
    logic [33:0] frm_data;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic [70:0] obs;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 collect, 2 stall, 3 drain; codes kept oldest-first.
    int          m_mode;
    int          m_codes[$];
    bit          m_ov;
    logic [33:0] m_data;
    bit          m_ovf;
    bit          m_endp;

    nios2_dct_trace_packer dut (
        .clk         (clk),
        .reset       (reset),
        .trace_en    (trace_en),
        .dct_valid   (dct_valid),
        .dct_code    (dct_code),
        .flush_req   (flush_req),
        .test_ending (test_ending),
        .overflow_clr(overflow_clr),
        .frm_ready   (frm_ready),
        .frm_valid   (frm_valid),
        .frm_data    (frm_data),
        .dct_buffer  (dct_buffer),
        .dct_count   (dct_count),
        .busy        (busy),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    assign obs = {frm_valid, frm_data, dct_buffer, dct_count, busy, overflow};

    // Newest code ends up least significant: value = sum code_i * 4^(n-1-i).
    function automatic logic [33:0] pack(input int q[$]);
        longint unsigned v = 0;
        logic [63:0]     w;
        logic [3:0]      c;
        foreach (q[i]) v = v * 4 + longint'(q[i]);
        w = v;
        c = 4'(q.size());
        return {c, w[29:0]};
    endfunction

    function automatic logic [70:0] exp_vec();
        logic [33:0] p;
        p = pack(m_codes);
        return {m_ov, m_data, p[29:0], p[33:30], (m_mode != 0) || m_ov, m_ovf};
    endfunction

    function automatic void model_step();
        bit          xfer, free, load, ending, close, ovf_set;
        logic [33:0] fr;
        if (reset) begin
            m_mode = 0; m_codes.delete(); m_ov = 0; m_data = '0; m_ovf = 0; m_endp = 0;
            return;
        end
        xfer = m_ov && frm_ready;
        free = !m_ov || frm_ready;
        load = 0; ovf_set = 0; fr = '0;
        case (m_mode)
            0: if (trace_en) m_mode = 1;
            1: begin
                if (dct_valid) m_codes.push_back(int'(dct_code));
                ending = !trace_en || test_ending;
                close  = (m_codes.size() == DEPTH) || flush_req || ending;
                if (close) begin
                    if (m_codes.size() == 0) m_mode = ending ? 3 : 1;
                    else if (free) begin
                        fr = pack(m_codes); load = 1; m_codes.delete();
                        m_mode = ending ? 3 : 1;
                    end else begin
                        m_mode = 2; m_endp = test_ending;
                    end
                end
            end
            2: begin
                if (dct_valid) ovf_set = 1;
                if (test_ending) m_endp = 1;
                if (frm_ready) begin
                    fr = pack(m_codes); load = 1; m_codes.delete();
                    m_mode = (!trace_en || m_endp) ? 3 : 1;
                    m_endp = 0;
                end
            end
            default: if (free) m_mode = 0;
        endcase
        if (load) begin m_ov = 1; m_data = fr; end
        else if (xfer) m_ov = 0;
        if (ovf_set) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic quiet();
        reset = 0; dct_valid = 0; dct_code = '0; flush_req = 0; test_ending = 0;
        overflow_clr = 0;
    endtask

    task automatic test_reset();
        quiet(); trace_en = 0; frm_ready = 1; reset = 1;
        cycle();
        reset = 0;
        n_cmp++;
        if (obs !== 71'd0) begin
            n_err++; $display("FAIL reset_state: got %h want 0", obs);
        end
    endtask

    task automatic test_full_frame();
        quiet(); trace_en = 1; frm_ready = 1;
        cycle();
        for (int i = 0; i < DEPTH; i++) begin
            dct_valid = 1; dct_code = 2'b01;
            cycle();
        end
        dct_valid = 0;
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_data !== 34'h3D5555555 || dct_count !== 4'd0) begin
            n_err++;
            $display("FAIL full_frame: got v=%b d=%h c=%0d want v=1 d=3d5555555 c=0",
                     frm_valid, frm_data, dct_count);
        end
        cycle();
        n_cmp++;
        if (frm_valid !== 1'b0) begin
            n_err++; $display("FAIL full_frame_xfer: got v=%b want 0", frm_valid);
        end
    endtask

    task automatic test_flush();
        int codes[3] = '{3, 2, 1};
        quiet();
        foreach (codes[i]) begin
            dct_valid = 1; dct_code = 2'(codes[i]);
            cycle();
        end
        dct_valid = 0; flush_req = 1;
        cycle();
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_data !== {4'd3, 30'h39}) begin
            n_err++; $display("FAIL flush_frame: got v=%b d=%h want v=1 d=%h",
                              frm_valid, frm_data, {4'd3, 30'h39});
        end
        cycle();
        flush_req = 0;
        n_cmp++;
        if (frm_valid !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL flush_empty: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_stall_overflow();
        int          q1[$];
        int          q2[$];
        logic [33:0] f1, f2;
        quiet(); overflow_clr = 1; frm_ready = 0;
        cycle();
        overflow_clr = 0;
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            dct_valid = 1; dct_code = 2'($urandom_range(0, 3));
            if (i < DEPTH) q1.push_back(int'(dct_code));
            else if (i < 2 * DEPTH) q2.push_back(int'(dct_code));
            cycle();
        end
        dct_valid = 0;
        f1 = pack(q1); f2 = pack(q2);
        n_cmp++;
        if (overflow !== 1'b1 || frm_data !== f1 || dct_count !== 4'd15 || busy !== 1'b1) begin
            n_err++; $display("FAIL stall_hold: got ov=%b d=%h c=%0d want ov=1 d=%h c=15",
                              overflow, frm_data, dct_count, f1);
        end
        frm_ready = 1;
        cycle();
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_data !== f2) begin
            n_err++; $display("FAIL stall_frame2: got d=%h want %h", frm_data, f2);
        end
        cycle();
        n_cmp++;
        if (frm_valid !== 1'b0 || dct_count !== 4'd0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL stall_release: got %h want %h", obs, exp_vec());
        end
        overflow_clr = 1;
        cycle();
        overflow_clr = 0;
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL overflow_clr: got %b want 0", overflow);
        end
    endtask

    task automatic test_code_with_flush();
        quiet(); frm_ready = 1;
        for (int i = 0; i < 4; i++) begin
            dct_valid = 1; dct_code = 2'($urandom_range(0, 3));
            cycle();
        end
        dct_code = 2'd2; flush_req = 1;
        cycle();
        quiet();
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_data[33:30] !== 4'd5 || frm_data[1:0] !== 2'd2 ||
            obs !== exp_vec()) begin
            n_err++; $display("FAIL code_with_flush: got %h want count 5 low 2 (%h)",
                              frm_data, exp_vec());
        end
    endtask

    task automatic test_test_ending();
        quiet(); frm_ready = 1;
        for (int i = 0; i < 7; i++) begin
            dct_valid = 1; dct_code = 2'($urandom_range(0, 3));
            cycle();
        end
        dct_valid = 0; test_ending = 1; trace_en = 0;
        cycle();
        test_ending = 0;
        n_cmp++;
        if (frm_valid !== 1'b1 || frm_data[33:30] !== 4'd7 || busy !== 1'b1) begin
            n_err++; $display("FAIL test_ending_frame: got v=%b d=%h want count 7",
                              frm_valid, frm_data);
        end
        cycle();
        n_cmp++;
        if (busy !== 1'b0 || frm_valid !== 1'b0) begin
            n_err++; $display("FAIL drain_idle: got busy=%b v=%b want 0 0", busy, frm_valid);
        end
        for (int i = 0; i < 3; i++) begin
            dct_valid = 1; dct_code = 2'd3; flush_req = 1; test_ending = 1;
            cycle();
        end
        quiet();
        n_cmp++;
        if (dct_count !== 4'd0 || busy !== 1'b0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL idle_ignore: got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_reset_midop();
        quiet(); trace_en = 1; frm_ready = 0;
        cycle();
        for (int i = 0; i < DEPTH + 9; i++) begin
            dct_valid = 1; dct_code = 2'($urandom_range(0, 3));
            cycle();
        end
        dct_valid = 0;
        n_cmp++;
        if (frm_valid !== 1'b1 || dct_count !== 4'd9) begin
            n_err++; $display("FAIL midop_setup: got v=%b c=%0d want 1 9", frm_valid, dct_count);
        end
        reset = 1;
        cycle();
        reset = 0;
        n_cmp++;
        if (obs !== 71'd0 || obs !== exp_vec()) begin
            n_err++; $display("FAIL reset_midop: got %h want 0", obs);
        end
    endtask

    task automatic test_random();
        quiet(); trace_en = 1; frm_ready = 1;
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 29) == 0) trace_en = ~trace_en;
            dct_valid    = ($urandom_range(0, 1) == 1);
            dct_code     = 2'($urandom_range(0, 3));
            flush_req    = ($urandom_range(0, 19) == 0);
            test_ending  = ($urandom_range(0, 49) == 0);
            overflow_clr = ($urandom_range(0, 19) == 0);
            frm_ready    = ($urandom_range(0, 9) < 4);
            cycle();
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++; $display("FAIL random cycle %0d: got %h want %h", i, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_stall_overflow();
        test_code_with_flush();
        test_test_ending();
        test_reset_midop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
